// File: rtl/mod10_chk_pkg.sv
// Shared types and constants for the mod-10 up/down counter checker.
package mod10_chk_pkg;

  localparam int DATA_W = 4;
  localparam int MOD_N = 10;
  localparam logic [DATA_W-1:0] MAX_VAL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RESYNC = 2'd2
  } chk_state_e;

  // Plain vector constants so the state register stays a bare 2-bit logic.
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_CHECK  = ST_CHECK;
  localparam logic [1:0] S_RESYNC = ST_RESYNC;

  function automatic logic is_legal(input logic [DATA_W-1:0] v);
    return v <= MAX_VAL;
  endfunction

endpackage

// File: rtl/mod10_ref_model.sv
// Next-prediction logic for the observed mod-10 counter: reset, load, up or down with wrap.
module mod10_ref_model
  import mod10_chk_pkg::*;
(
  input  logic              mon_rst,
  input  logic              mon_load,
  input  logic              mon_mode,
  input  logic [DATA_W-1:0] mon_data_in,
  input  logic [DATA_W-1:0] pred,
  output logic [DATA_W-1:0] pred_next
);

  // Out-of-range predictions (after an illegal load) fold back to 0 when counting up.
  always_comb begin
    pred_next = pred;
    if (mon_rst) begin
      pred_next = '0;
    end else if (mon_load) begin
      pred_next = mon_data_in;
    end else if (mon_mode) begin
      pred_next = (pred >= MAX_VAL) ? '0 : pred + 4'd1;
    end else begin
      pred_next = (pred == '0) ? MAX_VAL : pred - 4'd1;
    end
  end

endmodule

// File: rtl/mod10_checker.sv
// Scoreboard for a mod-10 up/down counter: predicts its output, compares, and counts errors.
module mod10_checker
  import mod10_chk_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ILL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_en,
  input  logic              clr_cnt,
  input  logic              mon_rst,
  input  logic              mon_mode,
  input  logic              mon_load,
  input  logic [DATA_W-1:0] mon_data_in,
  input  logic [DATA_W-1:0] mon_data_out,
  output logic [DATA_W-1:0] exp_out,
  output logic [1:0]        state,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  check_count,
  output logic [ILL_W-1:0]  illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ILL_W-1:0] ILL_MAX = '1;

  logic [DATA_W-1:0] pred;
  logic [DATA_W-1:0] pred_next;
  logic [1:0]        state_next;
  logic              first_edge;
  logic              do_cmp;
  logic              mismatch;
  logic              illegal_ld;

  mod10_ref_model u_ref_model (
    .mon_rst     (mon_rst),
    .mon_load    (mon_load),
    .mon_mode    (mon_mode),
    .mon_data_in (mon_data_in),
    .pred        (pred),
    .pred_next   (pred_next)
  );

  // The observed counter and pred both move on the same edge, so compare against the old pred.
  assign do_cmp     = (state == S_CHECK) && chk_en && !first_edge;
  assign mismatch   = do_cmp && (mon_data_out != pred);
  assign illegal_ld = (state == S_CHECK) && !mon_rst && mon_load && !is_legal(mon_data_in);
  assign exp_out    = pred;

  always_comb begin
    state_next = state;
    if (mon_rst) begin
      state_next = S_CHECK;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_CHECK:  if (illegal_ld) state_next = S_RESYNC;
        S_RESYNC: if (mon_load && is_legal(mon_data_in)) state_next = S_CHECK;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // first_edge masks the comparison on the edge right after CHECK is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pred       <= '0;
      first_edge <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_next;
      pred       <= pred_next;
      first_edge <= (state_next == S_CHECK) && (state != S_CHECK);
      err_pulse  <= mismatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky    <= 1'b0;
      err_count     <= '0;
      check_count   <= '0;
      illegal_count <= '0;
    end else if (clr_cnt) begin
      err_sticky    <= 1'b0;
      err_count     <= '0;
      check_count   <= '0;
      illegal_count <= '0;
    end else begin
      if (do_cmp && (check_count != CNT_MAX)) begin
        check_count <= check_count + CNT_W'(1);
      end
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
      if (illegal_ld && (illegal_count != ILL_MAX)) begin
        illegal_count <= illegal_count + ILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod10_checker.sv
// Bench for mod10_checker: a directed vector table, saturation/reset sequences, then random stimulus vs a model.
module tb_mod10_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chk_en = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       mon_rst = 1'b0;
  logic       mon_mode = 1'b0;
  logic       mon_load = 1'b0;
  logic [3:0] mon_data_in = 4'd0;
  logic [3:0] mon_data_out = 4'd0;

  logic [3:0]  b_exp_out, s_exp_out;
  logic [1:0]  b_state, s_state;
  logic        b_pulse, s_pulse, b_sticky, s_sticky;
  logic [15:0] b_err, b_chk;
  logic [7:0]  b_ill;
  logic [3:0]  s_err, s_chk;
  logic [2:0]  s_ill;

  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mod10_checker u_big (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .mon_rst(mon_rst), .mon_mode(mon_mode), .mon_load(mon_load),
    .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .exp_out(b_exp_out), .state(b_state), .err_pulse(b_pulse), .err_sticky(b_sticky),
    .err_count(b_err), .check_count(b_chk), .illegal_count(b_ill)
  );

  mod10_checker #(.CNT_W(4), .ILL_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .mon_rst(mon_rst), .mon_mode(mon_mode), .mon_load(mon_load),
    .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .exp_out(s_exp_out), .state(s_state), .err_pulse(s_pulse), .err_sticky(s_sticky),
    .err_count(s_err), .check_count(s_chk), .illegal_count(s_ill)
  );

  // Model: phase 0 = waiting for counter reset, 1 = tracking, 2 = lost sync after a bad load.
  int  m_phase, m_pred, m_errs, m_checks, m_ills;
  bit  m_valid, m_fresh, m_sticky, m_pulse;

  function automatic void model_reset();
    m_phase = 0; m_pred = 0; m_valid = 1'b1; m_fresh = 1'b0;
    m_errs = 0; m_checks = 0; m_ills = 0; m_sticky = 1'b0; m_pulse = 1'b0;
  endfunction

  function automatic void model_step(input bit r, input bit ld, input bit md, input int din,
                                     input int dout, input bit en, input bit clr);
    bit cmp, bad, ill;
    int nphase;
    cmp = (m_phase == 1) && en && !m_fresh;
    bad = cmp && (dout != m_pred);
    ill = (m_phase == 1) && !r && ld && (din > 9);
    if (clr) begin
      m_errs = 0; m_checks = 0; m_ills = 0; m_sticky = 1'b0;
    end else begin
      if (cmp) m_checks++;
      if (bad) begin m_errs++; m_sticky = 1'b1; end
      if (ill) m_ills++;
    end
    m_pulse = bad;
    if (r) nphase = 1;
    else if (m_phase == 1 && ill) nphase = 2;
    else if (m_phase == 2 && ld && din <= 9) nphase = 1;
    else nphase = m_phase;
    m_fresh = (nphase == 1) && (m_phase != 1);
    m_phase = nphase;
    if (r) begin m_pred = 0; m_valid = 1'b1; end
    else if (ld) begin m_pred = din; m_valid = (din <= 9); end
    else if (m_valid && md) m_pred = (m_pred + 1) % 10;
    else if (m_valid) m_pred = (m_pred + 9) % 10;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic expect_eq(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string tag);
    expect_eq({tag, " big.state"}, int'(b_state), m_phase);
    expect_eq({tag, " small.state"}, int'(s_state), m_phase);
    if (m_valid) begin
      expect_eq({tag, " big.exp_out"}, int'(b_exp_out), m_pred);
      expect_eq({tag, " small.exp_out"}, int'(s_exp_out), m_pred);
    end
    expect_eq({tag, " big.err_pulse"}, int'(b_pulse), int'(m_pulse));
    expect_eq({tag, " small.err_pulse"}, int'(s_pulse), int'(m_pulse));
    expect_eq({tag, " big.err_sticky"}, int'(b_sticky), int'(m_sticky));
    expect_eq({tag, " small.err_sticky"}, int'(s_sticky), int'(m_sticky));
    expect_eq({tag, " big.err_count"}, int'(b_err), sat(m_errs, 16));
    expect_eq({tag, " small.err_count"}, int'(s_err), sat(m_errs, 4));
    expect_eq({tag, " big.check_count"}, int'(b_chk), sat(m_checks, 16));
    expect_eq({tag, " small.check_count"}, int'(s_chk), sat(m_checks, 4));
    expect_eq({tag, " big.illegal_count"}, int'(b_ill), sat(m_ills, 8));
    expect_eq({tag, " small.illegal_count"}, int'(s_ill), sat(m_ills, 3));
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, " state"}, int'(b_state) + int'(s_state), 0);
    expect_eq({tag, " exp_out"}, int'(b_exp_out) + int'(s_exp_out), 0);
    expect_eq({tag, " flags"}, int'(b_pulse) + int'(s_pulse) + int'(b_sticky) + int'(s_sticky), 0);
    expect_eq({tag, " counts"}, int'(b_err) + int'(b_chk) + int'(b_ill)
              + int'(s_err) + int'(s_chk) + int'(s_ill), 0);
  endtask

  // Drives one cycle of stimulus, advances the model on the edge, then compares.
  task automatic applyStimulus(input bit r, input bit ld, input bit md, input int din,
                               input int dout, input bit en, input bit clr, input string tag);
    mon_rst = r; mon_load = ld; mon_mode = md;
    mon_data_in = 4'(din); mon_data_out = 4'(dout);
    chk_en = en; clr_cnt = clr;
    @(posedge clk);
    model_step(r, ld, md, din, dout, en, clr);
    #1;
    checkOutput(tag);
  endtask

  typedef struct {
    bit r, ld, md; int din, dout; bit en, clr;
    bit exp_care; int exp_val; int st; bit pulse_care; bit pulse;
    bit sticky; int errs; int checks; int ills;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit r, input bit ld, input bit md, input int din,
                                  input int dout, input bit en, input bit clr,
                                  input bit exp_care, input int exp_val, input int st,
                                  input bit pulse_care, input bit pulse, input bit sticky,
                                  input int errs, input int checks, input int ills);
    vec_t v;
    v.r = r; v.ld = ld; v.md = md; v.din = din; v.dout = dout; v.en = en; v.clr = clr;
    v.exp_care = exp_care; v.exp_val = exp_val; v.st = st;
    v.pulse_care = pulse_care; v.pulse = pulse; v.sticky = sticky;
    v.errs = errs; v.checks = checks; v.ills = ills;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dout;
    string tag;
    model_reset();
    #12;
    check_all_zero("reset");

    // Counter reset, then count up 12 edges with the first edge after entry uncompared.
    add_vec(1,0,1,0,0,1,0, 1,0,1, 1,0, 0,0,0,0);
    for (int i = 1; i <= 12; i++) add_vec(0,0,1,0,(i-1)%10,1,0, 1,i%10,1, 1,0, 0,0,i-1,0);
    add_vec(0,1,0,7,2,1,0, 1,7,1, 1,0, 0,0,12,0);
    for (int k = 1; k <= 14; k++)
      add_vec(0,0,0,0,(17-(k-1))%10,1,0, 1,(17-k)%10,1, 1,0, 0,0,12+k,0);
    add_vec(0,0,0,0,5,1,0, 1,2,1, 1,1, 1,1,27,0);
    add_vec(0,0,0,0,2,1,0, 1,1,1, 1,0, 1,1,28,0);
    add_vec(0,1,0,12,1,1,0, 0,0,2, 1,0, 1,1,29,1);
    add_vec(0,0,1,0,0,1,0, 0,0,2, 1,0, 1,1,29,1);
    add_vec(0,1,1,4,0,1,0, 1,4,1, 1,0, 1,1,29,1);
    add_vec(0,0,1,0,4,1,0, 1,5,1, 1,0, 1,1,29,1);
    add_vec(0,0,1,0,5,1,0, 1,6,1, 1,0, 1,1,30,1);
    add_vec(1,1,1,6,6,1,0, 1,0,1, 1,0, 1,1,31,1);
    add_vec(0,0,1,0,0,1,0, 1,1,1, 1,0, 1,1,32,1);
    add_vec(0,0,1,0,9,1,1, 1,2,1, 0,0, 0,0,0,0);
    add_vec(0,0,1,0,2,1,0, 1,3,1, 1,0, 0,0,1,0);
    add_vec(0,0,1,0,9,0,0, 1,4,1, 1,0, 0,0,1,0);
    add_vec(0,0,1,0,4,1,0, 1,5,1, 1,0, 0,0,2,0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].r, vecs[i].ld, vecs[i].md, vecs[i].din, vecs[i].dout,
                    vecs[i].en, vecs[i].clr, tag);
      expect_eq({tag, " tbl.state"}, int'(b_state), vecs[i].st);
      if (vecs[i].exp_care) expect_eq({tag, " tbl.exp_out"}, int'(b_exp_out), vecs[i].exp_val);
      if (vecs[i].pulse_care) expect_eq({tag, " tbl.err_pulse"}, int'(b_pulse), int'(vecs[i].pulse));
      expect_eq({tag, " tbl.err_sticky"}, int'(b_sticky), int'(vecs[i].sticky));
      expect_eq({tag, " tbl.err_count"}, int'(b_err), vecs[i].errs);
      expect_eq({tag, " tbl.check_count"}, int'(b_chk), vecs[i].checks);
      expect_eq({tag, " tbl.small_check_count"}, int'(s_chk), sat(vecs[i].checks, 4));
      expect_eq({tag, " tbl.illegal_count"}, int'(b_ill), vecs[i].ills);
    end

    // Twenty consecutive mismatches: the 4-bit counter must hold at 15.
    for (int i = 0; i < 20; i++) applyStimulus(0,0,1,0,m_pred ^ 15,1,0, "satur");
    expect_eq("sat big.err_count", int'(b_err), 20);
    expect_eq("sat small.err_count", int'(s_err), 15);

    // Checker reset mid-run clears everything without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0,0,1,0,7,1,0, "postreset");
    expect_eq("postreset check_count", int'(b_chk), 0);
    applyStimulus(1,0,1,0,3,1,0, "rearm");

    for (int i = 0; i < 600; i++) begin
      if (!m_valid || $urandom_range(0, 7) == 0) dout = int'($urandom_range(0, 15));
      else dout = m_pred;
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), dout,
                    $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
